// File: rtl/gerador_rodadas.sv
`default_nettype none
// ============================================================================
// Module   : gerador_rodadas
// Purpose  : Round sequencer for the band-guessing game. Each round draws a
//            pseudo-random 10 cm band, then repeatedly waits, requests a
//            measurement and listens for a hit, until the player hits or runs
//            out of measurements. Rounds are counted and hits are scored.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   iniciar    in   1   start-game request (honoured only in OCIOSO/FIM)
//   acertou    in   1   hit pulse from medidor_faixa (honoured only in AGUARDA)
//   medir      out  1   one-cycle measure request
//   upperL     out  12  upper band limit, 3-digit BCD cm
//   lowerL     out  12  lower band limit, 3-digit BCD cm
//   rodada     out  4   current round, 0-based
//   pontos     out  4   rounds hit so far
//   em_jogo    out  1   game in progress
//   fim        out  1   game over
//   db_estado  out  3   current state encoding
// ============================================================================
module gerador_rodadas #(
  parameter int INTERVALO   = 3_000_000,
  parameter int JANELA      = 1_500_000,
  parameter int MEDIDAS     = 8,
  parameter int NUM_RODADAS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        acertou,
  output logic        medir,
  output logic [11:0] upperL,
  output logic [11:0] lowerL,
  output logic [3:0]  rodada,
  output logic [3:0]  pontos,
  output logic        em_jogo,
  output logic        fim,
  output logic [2:0]  db_estado
);

  // One timer serves both ESPERA and AGUARDA, so it is sized for the longer.
  localparam int C_TIMER_MAX = (INTERVALO > JANELA) ? INTERVALO : JANELA;
  localparam int C_TIMER_W   = (C_TIMER_MAX > 1) ? $clog2(C_TIMER_MAX) : 1;
  localparam int C_MED_W     = $clog2(MEDIDAS + 1);
  localparam logic [7:0] C_SEMENTE = 8'hA5;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    SORTEIA = 3'd1,
    ESPERA  = 3'd2,
    MEDE    = 3'd3,
    AGUARDA = 3'd4,
    PROXIMA = 3'd5,
    FIM     = 3'd6
  } estado_t;

  estado_t              r_estado;
  estado_t              w_prox_estado;
  logic [C_TIMER_W-1:0] r_timer;
  logic [C_MED_W-1:0]   r_medidas;
  logic [7:0]           r_lfsr;
  logic [11:0]          r_upper;
  logic [11:0]          r_lower;
  logic [3:0]           r_rodada;
  logic [3:0]           r_pontos;

  logic                 w_fim_espera;
  logic                 w_fim_janela;
  logic                 w_ultima_rodada;
  logic                 w_realim;
  logic [3:0]           w_digito_inf;
  logic [3:0]           w_digito_sup;

  assign w_fim_espera    = (r_timer == C_TIMER_W'(INTERVALO - 1));
  assign w_fim_janela    = (r_timer == C_TIMER_W'(JANELA - 1));
  assign w_ultima_rodada = (r_rodada == 4'(NUM_RODADAS - 1));
  assign w_realim        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Tens digit of the band: idx 0..7 gives lower 1..8, upper 2..9, so the
  // digits always stay valid BCD.
  assign w_digito_inf = {1'b0, r_lfsr[2:0]} + 4'd1;
  assign w_digito_sup = {1'b0, r_lfsr[2:0]} + 4'd2;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_prox_estado = r_estado;
    medir         = 1'b0;
    em_jogo       = 1'b1;
    fim           = 1'b0;
    db_estado     = r_estado;

    case (r_estado)
      OCIOSO: begin
        em_jogo = 1'b0;
        if (iniciar) w_prox_estado = SORTEIA;
      end
      SORTEIA: w_prox_estado = ESPERA;
      ESPERA: begin
        if (w_fim_espera) w_prox_estado = MEDE;
      end
      MEDE: begin
        medir         = 1'b1;
        w_prox_estado = AGUARDA;
      end
      AGUARDA: begin
        // A hit in the very cycle the window closes still counts.
        if (acertou) begin
          w_prox_estado = PROXIMA;
        end else if (w_fim_janela) begin
          w_prox_estado = (r_medidas == C_MED_W'(MEDIDAS)) ? PROXIMA : ESPERA;
        end
      end
      PROXIMA: w_prox_estado = w_ultima_rodada ? FIM : SORTEIA;
      FIM: begin
        em_jogo = 1'b0;
        fim     = 1'b1;
        if (iniciar) w_prox_estado = SORTEIA;
      end
      default: begin
        em_jogo       = 1'b0;
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: timer, measurement counter, LFSR, band, round and score
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer   <= '0;
      r_medidas <= '0;
      r_lfsr    <= C_SEMENTE;
      r_upper   <= 12'h000;
      r_lower   <= 12'h000;
      r_rodada  <= 4'd0;
      r_pontos  <= 4'd0;
    end else begin
      // The timer restarts on every state change, so each timed state starts
      // counting from zero on entry.
      if ((w_prox_estado != r_estado) ||
          !((r_estado == ESPERA) || (r_estado == AGUARDA))) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      case (r_estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            r_rodada  <= 4'd0;
            r_pontos  <= 4'd0;
            r_medidas <= '0;
          end
        end
        SORTEIA: begin
          r_lfsr    <= {r_lfsr[6:0], w_realim};
          r_lower   <= {4'h0, w_digito_inf, 4'h0};
          r_upper   <= {4'h0, w_digito_sup, 4'h0};
          r_medidas <= '0;
        end
        MEDE: r_medidas <= r_medidas + 1'b1;
        AGUARDA: begin
          if (acertou) r_pontos <= r_pontos + 4'd1;
        end
        PROXIMA: begin
          if (!w_ultima_rodada) r_rodada <= r_rodada + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign upperL = r_upper;
  assign lowerL = r_lower;
  assign rodada = r_rodada;
  assign pontos = r_pontos;

endmodule
`default_nettype wire
